fifo_stat: RTL

- Parametrised synchronous FIFO. Successor to the basic FIFO used in the datapath buffering between Paillier modular-arithmetic stages.
- Adds over the basic FIFO:
  - configurable almost-full / almost-empty thresholds
  - occupancy count
  - selectable standard-read or first-word-fall-through (FWFT) mode
  - a read-valid strobe
  - sticky overflow/underflow error flags
  - a synchronous flush

---
 rtl/fifo_stat.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fifo_stat.sv
// Synchronous FIFO with occupancy count, threshold flags, sticky error
// flags, synchronous flush and selectable standard or FWFT read port.
module fifo_stat #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fifo_stat: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             rd_acc;
    logic             wr_acc;

    // A full FIFO still takes a write when a pop frees a slot this edge.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    always_comb begin
        count_nxt = count;
        unique case (1'b1)
            (wr_acc & ~rd_acc): count_nxt = count + ONE_CNT;
            (rd_acc & ~wr_acc): count_nxt = count - ONE_CNT;
            default:            count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (clr) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ONE_PTR;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ONE_PTR;
            end
            count        <= count_nxt;
            full         <= (count_nxt == FULL_CNT);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_CNT);
            almost_empty <= (count_nxt <= AE_CNT);
            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Storage is never reset; contents are unreachable until rewritten.
    always_ff @(posedge clk) begin
        if (wr_acc && !clr && !rst) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign rd_data  = mem[rd_ptr];
        assign rd_valid = ~empty;
    end else begin : g_std
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_data  <= '0;
                rd_valid <= 1'b0;
            end else if (clr) begin
                rd_data  <= '0;
                rd_valid <= 1'b0;
            end else begin
                rd_valid <= rd_acc;
                if (rd_acc) begin
                    rd_data <= mem[rd_ptr];
                end
            end
        end
    end

endmodule
